// File: rtl/bist_pkg.sv
// Shared definitions for the BIST sequencer: FSM state encoding, result
// width and the signature / run-counter field positions inside the result.
package bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_TEST_PULSE = 3'd1,
        ST_START      = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_RESP       = 3'd4
    } state_e;

    localparam int RES_W   = 13;
    localparam int SIG_W   = 9;
    localparam int RUN_W   = 4;
    localparam int SIG_LSB = 0;
    localparam int SIG_MSB = 8;
    localparam int RUN_LSB = 9;
    localparam int RUN_MSB = 12;

    // True when the result carries the golden signature and the expected run tag.
    function automatic logic sig_match(input logic [RES_W-1:0] y,
                                       input logic [SIG_W-1:0] golden,
                                       input logic [RUN_W-1:0] run);
        return (y[SIG_MSB:SIG_LSB] == golden) && (y[RUN_MSB:RUN_LSB] == run);
    endfunction

endpackage

// File: rtl/bist_timeout.sv
// Cycle counter used to bound the waits for DUT busy edges. expired_o is
// high during the LIMIT-th enabled cycle since the last clear, so the FSM
// leaves the waiting state exactly LIMIT cycles after entering it.
module bist_timeout #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear has priority; otherwise count up while enabled and not yet expired.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !expired_o) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Expiry flag: the awaited edge has not come within LIMIT cycles.
    always_comb begin
        expired_o = enable_i && (count_q == CNT_W'(LIMIT - 1));
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bist_sequencer.sv
// BIST sequencer: accepts user or BIST commands, drives the DUT through an
// optional test-mode pulse and a start/busy handshake, and returns the
// captured result with pass/timeout flags. All outputs are registered.
module bist_sequencer
    import bist_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC    = 1024,
    parameter int unsigned TEST_PULSE_CYC = 100,
    parameter logic [8:0]  GOLDEN_SIG     = 9'b001010001
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_mode_i,
    input  logic [7:0]  cmd_a_i,
    input  logic [7:0]  cmd_b_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [12:0] rsp_data_o,
    output logic        rsp_pass_o,
    output logic        rsp_timeout_o,
    output logic [7:0]  dut_a_o,
    output logic [7:0]  dut_b_o,
    output logic        dut_start_o,
    output logic        dut_test_o,
    input  logic        dut_busy_i,
    input  logic [12:0] dut_y_i
);

    localparam int unsigned PULSE_W = $clog2(TEST_PULSE_CYC + 1);

    state_e             state_q;
    logic               mode_q;
    logic [7:0]         dut_a_q;
    logic [7:0]         dut_b_q;
    logic               dut_start_q;
    logic               dut_test_q;
    logic               cmd_ready_q;
    logic               rsp_valid_q;
    logic [RES_W-1:0]   rsp_data_q;
    logic               rsp_pass_q;
    logic               rsp_timeout_q;
    logic [RUN_W-1:0]   run_q;
    logic [PULSE_W-1:0] pulse_q;

    logic [RUN_W-1:0]   run_inc_s;
    logic               tmo_clear_s;
    logic               tmo_enable_s;
    logic               tmo_expired_s;

    // Timeout runs only in START/WAIT_DONE and restarts on entry to each of them.
    always_comb begin
        run_inc_s    = run_q + {{(RUN_W-1){1'b0}}, 1'b1};
        tmo_enable_s = (state_q == ST_START) || (state_q == ST_WAIT_DONE);
        tmo_clear_s  = !tmo_enable_s || ((state_q == ST_START) && dut_busy_i);
    end

    bist_timeout #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clear_i   (tmo_clear_s),
        .enable_i  (tmo_enable_s),
        .expired_o (tmo_expired_s)
    );

    // Main sequencing FSM with all outputs registered.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            mode_q        <= 1'b0;
            dut_a_q       <= 8'd0;
            dut_b_q       <= 8'd0;
            dut_start_q   <= 1'b0;
            dut_test_q    <= 1'b0;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= {RES_W{1'b0}};
            rsp_pass_q    <= 1'b0;
            rsp_timeout_q <= 1'b0;
            run_q         <= {RUN_W{1'b0}};
            pulse_q       <= {PULSE_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i && cmd_ready_q) begin
                        mode_q      <= cmd_mode_i;
                        dut_a_q     <= cmd_a_i;
                        dut_b_q     <= cmd_b_i;
                        cmd_ready_q <= 1'b0;
                        pulse_q     <= {PULSE_W{1'b0}};
                        if (cmd_mode_i) begin
                            dut_test_q <= 1'b1;
                            state_q    <= ST_TEST_PULSE;
                        end else begin
                            dut_start_q <= 1'b1;
                            state_q     <= ST_START;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                ST_TEST_PULSE: begin
                    if (pulse_q == PULSE_W'(TEST_PULSE_CYC - 1)) begin
                        dut_test_q  <= 1'b0;
                        dut_start_q <= 1'b1;
                        state_q     <= ST_START;
                    end else begin
                        pulse_q <= pulse_q + {{(PULSE_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_START: begin
                    // dut_start_o has been high for at least this cycle, so a
                    // busy already high on entry still sees a start pulse.
                    if (dut_busy_i) begin
                        dut_start_q <= 1'b0;
                        state_q     <= ST_WAIT_DONE;
                    end else if (tmo_expired_s) begin
                        dut_start_q   <= 1'b0;
                        rsp_data_q    <= {RES_W{1'b0}};
                        rsp_pass_q    <= 1'b0;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= ST_RESP;
                    end else begin
                        dut_start_q <= 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!dut_busy_i) begin
                        rsp_data_q    <= dut_y_i;
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        if (mode_q) begin
                            run_q      <= run_inc_s;
                            rsp_pass_q <= sig_match(dut_y_i, GOLDEN_SIG, run_inc_s);
                        end else begin
                            rsp_pass_q <= 1'b0;
                        end
                        state_q <= ST_RESP;
                    end else if (tmo_expired_s) begin
                        rsp_data_q    <= {RES_W{1'b0}};
                        rsp_pass_q    <= 1'b0;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= ST_RESP;
                    end else begin
                        state_q <= ST_WAIT_DONE;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        rsp_valid_q <= 1'b1;
                    end
                end
                default: begin
                    dut_start_q <= 1'b0;
                    dut_test_q  <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_data_o    = rsp_data_q;
    assign rsp_pass_o    = rsp_pass_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign dut_a_o       = dut_a_q;
    assign dut_b_o       = dut_b_q;
    assign dut_start_o   = dut_start_q;
    assign dut_test_o    = dut_test_q;

endmodule

// File: tb/tb_bist_sequencer.sv
// Directed self-checking bench for bist_sequencer with a behavioural DUT model.
module tb_bist_sequencer;

    localparam int          TMO   = 1024;
    localparam int          PULSE = 100;
    localparam logic [8:0]  GOLD  = 9'b001010001;
    localparam logic [8:0]  BAD   = 9'b001010000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_mode = 1'b0;
    logic [7:0]  cmd_a = 8'd0;
    logic [7:0]  cmd_b = 8'd0;
    logic        rsp_valid_o;
    logic        rsp_ready = 1'b0;
    logic [12:0] rsp_data_o;
    logic        rsp_pass_o;
    logic        rsp_timeout_o;
    logic [7:0]  dut_a_o;
    logic [7:0]  dut_b_o;
    logic        dut_start_o;
    logic        dut_test_o;
    logic        dut_busy = 1'b0;
    logic [12:0] dut_y = 13'd0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic        model_en = 1'b1;
    int          busy_cyc = 20;
    logic [12:0] model_y = 13'd0;

    bist_sequencer #(
        .TIMEOUT_CYC    (TMO),
        .TEST_PULSE_CYC (PULSE),
        .GOLDEN_SIG     (GOLD)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_mode_i    (cmd_mode),
        .cmd_a_i       (cmd_a),
        .cmd_b_i       (cmd_b),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready),
        .rsp_data_o    (rsp_data_o),
        .rsp_pass_o    (rsp_pass_o),
        .rsp_timeout_o (rsp_timeout_o),
        .dut_a_o       (dut_a_o),
        .dut_b_o       (dut_b_o),
        .dut_start_o   (dut_start_o),
        .dut_test_o    (dut_test_o),
        .dut_busy_i    (dut_busy),
        .dut_y_i       (dut_y)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // DUT model: on a sampled start, raise busy for busy_cyc cycles, then present model_y.
    always begin
        @(posedge clk);
        if (model_en && dut_start_o && !dut_busy) begin
            #1 dut_busy = 1'b1;
            dut_y = 13'd0;
            repeat (busy_cyc) @(posedge clk);
            #1 dut_busy = 1'b0;
            dut_y = model_y;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic mode, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        chk("cmd_ready_idle", 32'(cmd_ready_o), 32'd1);
        cmd_valid = 1'b1;
        cmd_mode  = mode;
        cmd_a     = a;
        cmd_b     = b;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        while (!rsp_valid_o && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd1);
    endtask

    task automatic ack();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk("ack_valid_low", 32'(rsp_valid_o), 32'd0);
        chk("ack_ready_high", 32'(cmd_ready_o), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready_o), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'd0);
        chk({tag, "_rsp_data"}, 32'(rsp_data_o), 32'd0);
        chk({tag, "_rsp_pass"}, 32'(rsp_pass_o), 32'd0);
        chk({tag, "_rsp_timeout"}, 32'(rsp_timeout_o), 32'd0);
        chk({tag, "_dut_a"}, 32'(dut_a_o), 32'd0);
        chk({tag, "_dut_b"}, 32'(dut_b_o), 32'd0);
        chk({tag, "_dut_start"}, 32'(dut_start_o), 32'd0);
        chk({tag, "_dut_test"}, 32'(dut_test_o), 32'd0);
    endtask

    initial begin
        int n;
        int cyc0;
        logic [12:0] exp_y;

        // Reset state.
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("reset_release_ready", 32'(cmd_ready_o), 32'd1);

        // User command: a=12, b=60, result 3 after 20 busy cycles.
        busy_cyc = 20;
        model_y  = 13'd3;
        send_cmd(1'b0, 8'd12, 8'd60);
        chk("user_dut_a", 32'(dut_a_o), 32'd12);
        chk("user_dut_b", 32'(dut_b_o), 32'd60);
        chk("user_start", 32'(dut_start_o), 32'd1);
        chk("user_test", 32'(dut_test_o), 32'd0);
        chk("user_ready_low", 32'(cmd_ready_o), 32'd0);
        wait_rsp("user");
        chk("user_data", 32'(rsp_data_o), 32'd3);
        chk("user_pass", 32'(rsp_pass_o), 32'd0);
        chk("user_timeout", 32'(rsp_timeout_o), 32'd0);
        ack();

        // Four passing BIST runs tagged 1..4.
        busy_cyc = 7;
        for (int r = 1; r <= 4; r++) begin
            model_y = {4'(r), GOLD};
            send_cmd(1'b1, 8'hA5, 8'h5A);
            chk("bist_test_high", 32'(dut_test_o), 32'd1);
            if (r == 1) begin
                n = 0;
                for (int k = 0; k < 500; k++) begin
                    @(negedge clk);
                    if (dut_test_o) n++;
                    else break;
                end
                chk("bist_pulse_len", 32'(n), 32'(PULSE));
                chk("bist_start_after_pulse", 32'(dut_start_o), 32'd1);
            end
            wait_rsp("bist");
            chk("bist_pass", 32'(rsp_pass_o), 32'd1);
            chk("bist_run_field", 32'(rsp_data_o[12:9]), 32'(r));
            chk("bist_timeout", 32'(rsp_timeout_o), 32'd0);
            ack();
        end

        // Wrong signature with correct run tag 5.
        model_y = {4'd5, BAD};
        send_cmd(1'b1, 8'h01, 8'h02);
        wait_rsp("badsig");
        chk("badsig_pass", 32'(rsp_pass_o), 32'd0);
        chk("badsig_data", 32'(rsp_data_o), 32'({4'd5, BAD}));
        ack();

        // Response back-pressure for 50 cycles, with a command offered meanwhile.
        busy_cyc = 3;
        exp_y    = 13'h1ABC;
        model_y  = exp_y;
        send_cmd(1'b0, 8'hFF, 8'h00);
        wait_rsp("bp");
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (k == 10) begin
                cmd_valid = 1'b1;
                cmd_mode  = 1'b1;
            end
            chk("bp_valid", 32'(rsp_valid_o), 32'd1);
            chk("bp_data", 32'(rsp_data_o), 32'(exp_y));
            chk("bp_ready_low", 32'(cmd_ready_o), 32'd0);
        end
        cmd_valid = 1'b0;
        ack();
        @(negedge clk);
        chk("bp_no_accept_test", 32'(dut_test_o), 32'd0);
        chk("bp_no_accept_start", 32'(dut_start_o), 32'd0);

        // Busy never rises: timeout exactly TMO cycles after entering START.
        model_en = 1'b0;
        send_cmd(1'b0, 8'h11, 8'h22);
        cyc0 = cyc;
        n = 0;
        while (!rsp_timeout_o && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_flag", 32'(rsp_timeout_o), 32'd1);
        chk("tmo_latency", 32'(cyc - cyc0), 32'(TMO));
        chk("tmo_valid", 32'(rsp_valid_o), 32'd1);
        chk("tmo_data", 32'(rsp_data_o), 32'd0);
        chk("tmo_start_low", 32'(dut_start_o), 32'd0);
        chk("tmo_pass", 32'(rsp_pass_o), 32'd0);
        ack();
        model_en = 1'b1;

        // Run counter unchanged by the timeout: next BIST tag is 6.
        busy_cyc = 4;
        model_y  = {4'd6, GOLD};
        send_cmd(1'b1, 8'h33, 8'h44);
        wait_rsp("after_tmo");
        chk("after_tmo_pass", 32'(rsp_pass_o), 32'd1);
        chk("after_tmo_timeout", 32'(rsp_timeout_o), 32'd0);
        ack();

        // Asynchronous reset while waiting for busy to fall.
        busy_cyc = 40;
        model_y  = {4'd7, GOLD};
        send_cmd(1'b1, 8'h55, 8'h66);
        n = 0;
        while (!dut_busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_busy_seen", 32'(dut_busy), 32'd1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("async_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("async_rst_release_ready", 32'(cmd_ready_o), 32'd1);
        repeat (60) @(negedge clk);

        // Run counter restarted from 0: next BIST tag is 1.
        busy_cyc = 5;
        model_y  = {4'd1, GOLD};
        send_cmd(1'b1, 8'h77, 8'h88);
        wait_rsp("post_rst");
        chk("post_rst_pass", 32'(rsp_pass_o), 32'd1);
        chk("post_rst_data", 32'(rsp_data_o), 32'({4'd1, GOLD}));
        ack();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
